// File: rtl/muldiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The requester drives start/op/operands/cancel; the unit returns status and result.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cancel;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div_by_zero;

  modport master (output start, op, a, b, cancel,
                  input  busy, done, result, div_by_zero);
  modport slave  (input  start, op, a, b, cancel,
                  output busy, done, result, div_by_zero);
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiplier/divider: shift-add multiply, restoring divide,
// sign fix-up in a final cycle. hi/lo double as product or {remainder, quotient}.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  muldiv_iter_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, mb;
  logic               sa, sb;
  logic [2*WIDTH-1:0] res_q;
  logic               dbz_q;

  logic               accept, is_div, is_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign accept = (state == IDLE || state == DONE) && bus.start && !bus.cancel;
  assign is_div = bus.op[1];
  assign is_sgn = bus.op[0];
  assign a_neg  = is_sgn & bus.a[WIDTH-1];
  assign b_neg  = is_sgn & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;

  // One iteration step. Multiply keeps the multiplier in lo and shifts the
  // partial product down into it; divide shifts the dividend out of lo and
  // the quotient bits back in.
  logic [WIDTH:0]     madd, shl, dif;
  logic               take;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;

  always_comb begin
    madd    = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    mul_nxt = {madd, lo[WIDTH-1:1]};
    shl     = {hi, lo[WIDTH-1]};
    dif     = shl - {1'b0, mb};
    take    = shl >= {1'b0, mb};
    div_nxt = {(take ? dif[WIDTH-1:0] : shl[WIDTH-1:0]), lo[WIDTH-2:0], take};
  end

  logic [2*WIDTH-1:0] prod, mul_fin, fin;
  logic [WIDTH-1:0]   q_fin, r_fin;

  always_comb begin
    prod    = {hi, lo};
    mul_fin = (op_q[0] && (sa ^ sb)) ? -prod : prod;
    q_fin   = (op_q[0] && (sa ^ sb)) ? -lo : lo;
    r_fin   = (op_q[0] && sa) ? -hi : hi;
    fin     = op_q[1] ? {r_fin, q_fin} : mul_fin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      mb    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      res_q <= '0;
      dbz_q <= 1'b0;
    end else if (bus.cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q <= bus.op;
            cnt  <= '0;
            sa   <= a_neg;
            sb   <= b_neg;
            hi   <= '0;
            lo   <= is_div ? a_mag : b_mag;
            mb   <= is_div ? b_mag : a_mag;
            if (is_div && bus.b == '0) begin
              state <= DONE;
              res_q <= {bus.a, {WIDTH{1'b1}}};
              dbz_q <= 1'b1;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          {hi, lo} <= op_q[1] ? div_nxt : mul_nxt;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          res_q <= fin;
          dbz_q <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state == CALC) || (state == SIGN);
  assign bus.done        = (state == DONE);
  assign bus.result      = res_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Scenario bench for muldiv_iter: expected {div_by_zero, result} values are
// queued at issue and popped when done is observed.
module tb_muldiv_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus ();
  muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  logic [64:0] sb_q[$];

  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint            sa_ = longint'($signed(a));
    longint            sb_ = longint'($signed(b));
    longint unsigned   ua  = {32'b0, a};
    longint unsigned   ub  = {32'b0, b};
    longint            q, r;
    case (op)
      2'd0: return {1'b0, ua * ub};
      2'd1: return {1'b0, 64'(sa_ * sb_)};
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, 32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa_ / sb_;
        r = sa_ % sb_;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Drive one accepting cycle from a negedge; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [64:0] exp);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
  endtask

  // Counts negedges until done; lat = -1 if the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
    end
  endtask

  function automatic logic [64:0] pop_exp();
    if (sb_q.size() == 0) return 65'h0;
    return sb_q.pop_front();
  endfunction

  task automatic test_reset();
    bus.start = 0; bus.cancel = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    rst = 1'b1;
  endtask

  task automatic test_multu();
    int lat; logic [64:0] e;
    @(negedge clk);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 64'hFFFF_FFFE_0000_0001});
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL multu_busy: got %b expected 1", bus.busy); end
    wait_done(lat);
    e = pop_exp();
    checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    checks++; if ({bus.div_by_zero, bus.result} !== e) begin errors++; $display("FAIL multu_result: got %h expected %h", {bus.div_by_zero, bus.result}, e); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL multu_pulse: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [64:0] e;
    @(negedge clk);
    issue(2'd1, -32'sd3, 32'sd5, {1'b0, 64'hFFFF_FFFF_FFFF_FFF1});
    wait_done(lat);
    e = pop_exp();
    checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", lat); end
    checks++; if ({bus.div_by_zero, bus.result} !== e) begin errors++; $display("FAIL mult_result: got %h expected %h", {bus.div_by_zero, bus.result}, e); end
    issue(2'd3, -32'sd7, 32'sd2, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    checks++; if (bus.busy !== 1'b1 || bus.result !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL b2b_hold: got busy=%b result=%h expected 1 fffffffffffffff1", bus.busy, bus.result); end
    wait_done(lat);
    e = pop_exp();
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", lat); end
    checks++; if ({bus.div_by_zero, bus.result} !== e) begin errors++; $display("FAIL div_result: got %h expected %h", {bus.div_by_zero, bus.result}, e); end
  endtask

  task automatic test_div_zero();
    int lat; logic [64:0] e;
    @(negedge clk);
    issue(2'd2, 32'h1234_5678, 32'h0, {1'b1, 64'h1234_5678_FFFF_FFFF});
    wait_done(lat);
    e = pop_exp();
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
    checks++; if ({bus.div_by_zero, bus.result} !== e) begin errors++; $display("FAIL dbz_result: got %h expected %h", {bus.div_by_zero, bus.result}, e); end
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 64'h0000_0000_8000_0000});
    wait_done(lat);
    e = pop_exp();
    checks++; if (lat !== 34) begin errors++; $display("FAIL divovf_latency: got %0d expected 34", lat); end
    checks++; if ({bus.div_by_zero, bus.result} !== e) begin errors++; $display("FAIL divovf_result: got %h expected %h", {bus.div_by_zero, bus.result}, e); end
  endtask

  task automatic test_cancel();
    int n_done; logic [64:0] e;
    @(negedge clk);
    issue(2'd1, 32'd7, 32'd9, {1'b0, 64'd63});
    repeat (4) @(negedge clk);
    // A divide-by-zero request would finish at once if it were wrongly accepted.
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'h1; bus.b = 32'h0;
    @(posedge clk); #1; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL start_ignored: got busy=%b done=%b expected 1 0", bus.busy, bus.done); end
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk); #1; bus.cancel = 1'b0;
    e = pop_exp();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL cancel_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    n_done = 0;
    repeat (40) begin @(negedge clk); if (bus.done) n_done++; end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL cancel_no_done: got %0d pulses expected 0 (dropped %h)", n_done, e); end
    checks++; if ({bus.div_by_zero, bus.result} !== {1'b0, 64'h0000_0000_8000_0000}) begin errors++; $display("FAIL cancel_hold: got %h expected 00000000080000000", {bus.div_by_zero, bus.result}); end
    // cancel wins over a simultaneous start
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd3;
    @(posedge clk); #1; bus.start = 1'b0; bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_beats_start: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int lat, n_done; logic [64:0] e;
    @(negedge clk);
    issue(2'd2, 32'd1000, 32'd3, {1'b0, 32'd1, 32'd333});
    repeat (19) @(negedge clk);
    rst = 1'b0; #1;
    e = pop_exp();
    checks++; if (bus.result !== 64'h0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got %h/%b expected 0/0", bus.result, bus.div_by_zero); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_status: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    @(negedge clk); rst = 1'b1;
    n_done = 0;
    repeat (40) begin @(negedge clk); if (bus.done) n_done++; end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0 (dropped %h)", n_done, e); end
    issue(2'd2, 32'd100, 32'd7, {1'b0, 64'h0000_0002_0000_000E});
    wait_done(lat);
    e = pop_exp();
    checks++; if (lat !== 34) begin errors++; $display("FAIL after_rst_latency: got %0d expected 34", lat); end
    checks++; if ({bus.div_by_zero, bus.result} !== e) begin errors++; $display("FAIL after_rst_result: got %h expected %h", {bus.div_by_zero, bus.result}, e); end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [64:0] e; logic [1:0] op; logic [31:0] a, b;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'h0 : ((i % 2 == 1) ? ($urandom >> 26) | 32'h1 : $urandom);
      if (i % 3 == 0) @(negedge clk);
      exp_lat = (op[1] && b == 0) ? 1 : 34;
      issue(op, a, b, model(op, a, b));
      wait_done(lat);
      e = pop_exp();
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
      checks++; if ({bus.div_by_zero, bus.result} !== e) begin errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {bus.div_by_zero, bus.result}, e); end
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_back_to_back();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
